// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the serial subtractor.
// master drives the request side; slave is the subtractor itself.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             mode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin, mode,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin, mode,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: STEP borrow-ripple bits per clock, LSB first.
// The result outputs change only when an operation completes.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_sub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] xs, ys, acc, acc_nx;
  logic             x_msb, y_msb, br;
  logic [CW-1:0]    cnt;
  logic [STEP:0]    bc;
  logic [STEP-1:0]  dstep;

  // Borrow chain across the STEP cells handled in one clock.
  assign bc[0] = br;
  for (genvar i = 0; i < STEP; i++) begin : g_cell
    fs_cell u_cell (
      .x  (xs[i]),
      .y  (ys[i]),
      .bi (bc[i]),
      .d  (dstep[i]),
      .bo (bc[i+1])
    );
  end

  always_comb begin
    acc_nx = acc;
    acc_nx[cnt*STEP +: STEP] = dstep;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      xs       <= '0;
      ys       <= '0;
      acc      <= '0;
      x_msb    <= 1'b0;
      y_msb    <= 1'b0;
      br       <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            xs       <= bus.mode ? bus.b : bus.a;
            ys       <= bus.mode ? bus.a : bus.b;
            x_msb    <= bus.mode ? bus.b[WIDTH-1] : bus.a[WIDTH-1];
            y_msb    <= bus.mode ? bus.a[WIDTH-1] : bus.b[WIDTH-1];
            br       <= bus.bin;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          xs  <= xs >> STEP;
          ys  <= ys >> STEP;
          br  <= bc[STEP];
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            bus.diff <= acc_nx;
            bus.bout <= bc[STEP];
            bus.ovf  <= (x_msb != y_msb) && (acc_nx[WIDTH-1] != x_msb);
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (8/1 and 16/4 instances) with an
// expected-result queue filled at start and drained at each done.
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8))  i8();
  serial_sub_if #(.WIDTH(16)) i16();

  serial_sub #(.WIDTH(8), .STEP(1)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (i8)
  );

  serial_sub #(.WIDTH(16), .STEP(4)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (i16)
  );

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain integer subtraction, not a bit ripple.
  function automatic exp_t model(input int w, input int a, input int b, input bit bin, input bit mode);
    exp_t e;
    int   mask, x, y, full;
    mask = (1 << w) - 1;
    x    = mode ? (b & mask) : (a & mask);
    y    = mode ? (a & mask) : (b & mask);
    full = x - y - int'(bin);
    e.d  = 16'(full & mask);
    e.bo = (x < y + int'(bin));
    e.ov = (((x >> (w-1)) & 1) != ((y >> (w-1)) & 1)) &&
           (((full >> (w-1)) & 1) != ((x >> (w-1)) & 1));
    return e;
  endfunction

  task automatic drive(input int sel, input int a, input int b, input bit bin, input bit mode, input bit push);
    if (sel == 0) begin
      i8.a = a[7:0]; i8.b = b[7:0]; i8.bin = bin; i8.mode = mode; i8.start = 1'b1;
    end else begin
      i16.a = a[15:0]; i16.b = b[15:0]; i16.bin = bin; i16.mode = mode; i16.start = 1'b1;
    end
    if (push) q.push_back(model(sel ? 16 : 8, a, b, bin, mode));
    tick();
    i8.start  = 1'b0;
    i16.start = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int lat, input string tag);
    exp_t        e;
    bit          seen;
    int          c;
    logic        dn, bsy, bo, ov;
    logic [15:0] d;
    seen = 1'b0;
    c    = 0;
    for (int i = 1; i <= lat + 4 && !seen; i++) begin
      tick();
      dn = (sel == 0) ? i8.done : i16.done;
      if (dn) begin
        seen = 1'b1;
        c    = i;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (seen) begin
        bsy = (sel == 0) ? i8.busy : i16.busy;
        d   = (sel == 0) ? {8'h0, i8.diff} : i16.diff;
        bo  = (sel == 0) ? i8.bout : i16.bout;
        ov  = (sel == 0) ? i8.ovf : i16.ovf;
        chk({tag, "_latency"}, 32'(c), 32'(lat));
        chk({tag, "_busy_low"}, 32'(bsy), 32'd0);
        chk({tag, "_diff"}, 32'(d), 32'(e.d));
        chk({tag, "_bout"}, 32'(bo), 32'(e.bo));
        chk({tag, "_ovf"}, 32'(ov), 32'(e.ov));
      end
    end else begin
      chk({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int nd;
    i8.start = 0;  i8.a = 0;  i8.b = 0;  i8.bin = 0;  i8.mode = 0;
    i16.start = 0; i16.a = 0; i16.b = 0; i16.bin = 0; i16.mode = 0;

    rst = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(i8.busy), 0);
    chk("rst_done", 32'(i8.done), 0);
    chk("rst_diff", 32'(i8.diff), 0);
    chk("rst_bout_ovf", {30'd0, i8.bout, i8.ovf}, 0);
    chk("rst16_busy_done", {30'd0, i16.busy, i16.done}, 0);
    rst = 1'b1;
    tick();

    drive(0, 'h05, 'h03, 0, 0, 1);
    chk("basic_busy_high", 32'(i8.busy), 1);
    wait_done(0, 8, "basic");
    tick();
    chk("basic_done_one_cycle", 32'(i8.done), 0);

    drive(0, 'h00, 'h00, 1, 0, 1);
    wait_done(0, 8, "wrap");
    drive(0, 'h80, 'h01, 0, 0, 1);
    wait_done(0, 8, "ovf_pos");

    drive(0, 'h03, 'h05, 0, 1, 1);
    wait_done(0, 8, "swap");
    drive(0, 'h03, 'h05, 0, 0, 1);
    wait_done(0, 8, "noswap");

    // Start re-pulsed while busy must be ignored.
    drive(0, 'h10, 'h01, 0, 0, 1);
    tick(); tick();
    drive(0, 'hFF, 'h01, 1, 1, 0);
    wait_done(0, 5, "ignore");
    // Back-to-back: start in the DONE cycle.
    drive(0, 'h20, 'h20, 0, 0, 1);
    chk("b2b_done_dropped", 32'(i8.done), 0);
    chk("b2b_busy", 32'(i8.busy), 1);
    wait_done(0, 8, "b2b");
    tick();

    drive(0, 'h7F, 'hFF, 0, 0, 1);
    wait_done(0, 8, "ovf_neg");
    tick();

    // Reset during the 4th RUN cycle abandons the operation.
    drive(0, 'h55, 'h22, 0, 0, 1);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    void'(q.pop_back());
    chk("midrst_busy_done", {30'd0, i8.busy, i8.done}, 0);
    chk("midrst_diff", 32'(i8.diff), 0);
    chk("midrst_bout_ovf", {30'd0, i8.bout, i8.ovf}, 0);
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i8.done) nd++;
    end
    chk("midrst_no_done", 32'(nd), 0);

    drive(1, 'h1234, 'h0235, 0, 0, 1);
    chk("w16_busy_high", 32'(i16.busy), 1);
    wait_done(1, 4, "w16");
    tick();
    drive(1, 'h8000, 'h0001, 0, 0, 1);
    wait_done(1, 4, "w16_ovf");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Parametrised, multi-cycle W-bit subtractor.
- Successor to the single-bit full-subtractor cell: the same borrow-ripple arithmetic, applied STEP bits per clock over a WIDTH-bit operand.
- Adds a start/busy/done handshake, an operand-swap mode and a signed-overflow flag.
- Serves as the area-lean arithmetic unit wherever subtraction latency is not critical.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- STEP, 1, bits processed per clock; must divide WIDTH exactly. N = WIDTH/STEP processing cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  request; sampled only when not busy.
- a  in  WIDTH  minuend (mode=0).
- b  in  WIDTH  subtrahend (mode=0).
- bin  in  1  borrow-in into bit 0.
- mode  in  1  0: a-b-bin; 1: b-a-bin.
- busy  out  1  operation in progress.
- done  out  1  one-cycle result-valid pulse.
- diff  out  WIDTH  difference.
- bout  out  1  borrow-out (unsigned minuend < subtrahend+bin).
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset (rst=0 at a clk edge): busy=0, done=0, diff=0, bout=0, ovf=0; FSM to IDLE; internal operand/borrow registers cleared. Dominates all other inputs.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge k:
  - Latch minuend x and subtrahend y (x=a, y=b if mode=0, swapped if mode=1), borrow register = bin, step counter = 0.
  - busy=1, done=0; go to RUN.
- IDLE/DONE with start=0: hold.
  - DONE->IDLE after one cycle; done=0.
  - diff/bout/ovf hold last result.
- RUN, each edge:
  - Compute STEP LSB-first bits with full-subtractor equations: d = x^y^br, br' = (~x&y) | (~(x^y)&br).
  - Shift result bits into the diff accumulator; increment counter.
- After the Nth RUN edge (edge k+N):
  - diff = full result; bout = final borrow.
  - ovf = (x[MSB]!=y[MSB]) && (diff[MSB]!=x[MSB]), using latched x,y.
  - busy=0, done=1, state DONE.
- Latency: done high in the cycle after edge k+N, i.e. N cycles after start is sampled.
- diff/bout/ovf are not updated mid-operation:
  - They hold the previous result until edge k+N.
  - Partial results live in internal registers only.
- start while busy=1: ignored; no queueing; operands unaffected.
- start=1 in the DONE cycle: accepted (back-to-back). done still pulses exactly one cycle.
- a/b/bin/mode changes after the start edge: no effect on the running operation.
- Reset mid-RUN: operation abandoned; no done pulse afterwards; outputs zero.
- Wrap-around is modulo 2^WIDTH:
  - 0-0-1 yields all-ones with bout=1.
  - Borrow never wraps into bit 0 of the next operation.
- STEP=WIDTH is legal: single RUN cycle, N=1.

Test Plan:
- WIDTH=8, STEP=1; a=0x05, b=0x03, bin=0, mode=0, start pulse -> busy high 8 cycles; done pulse 8 cycles after start sampled; diff=0x02, bout=0, ovf=0.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
- mode=1, a=0x03, b=0x05, bin=0 -> diff=0x02, bout=0. Then mode=0 with the same operands -> diff=0xFE, bout=1, ovf=0.
- Start 0x10-0x01; re-pulse start with a=0xFF during busy -> ignored, result 0x0F. Start asserted in the DONE cycle with 0x20-0x20 -> accepted; second done exactly 8 cycles later; diff=0x00, bout=0.
- rst=0 on the 4th RUN cycle -> next edge busy=0, done=0, diff=0, bout=0, ovf=0; no done pulse for the following 16 cycles without start.
- WIDTH=16, STEP=4: a=0x1234, b=0x0235, bin=0 -> done after 4 cycles; diff=0x0FFF, bout=0, ovf=0.
